// File: rtl/alu_sequencer_if.sv
// Sequencer/ALU bundle: the instruction handshake plus the operand/result bus.
// The master side belongs to the sequencer; the slave side is the instruction source and the ALU.
interface alu_sequencer_if;
  logic        instr_valid;
  logic [21:0] instr;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [15:0] r2;
  logic [15:0] r3;
  logic [3:0]  D1;
  logic [6:0]  entrada;
  logic [15:0] saida;
  logic        fimop;
  logic        flag_ram;

  modport master (
    input  instr_valid, instr, saida, fimop,
    output instr_ready, opcode, r2, r3, D1, entrada, flag_ram
  );

  modport slave (
    output instr_valid, instr, saida, fimop,
    input  instr_ready, opcode, r2, r3, D1, entrada, flag_ram
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: accepts one instruction, issues operands, waits for fimop and
// writes saida back. Define ALU_TIMEOUT_EN to add a 255-cycle fimop watchdog with sticky err.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.master bus,
  input  logic [3:0]      dbg_addr,
  output logic [15:0]     dbg_data,
  output logic            busy,
  output logic [15:0]     retired,
  output logic            err
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitFim, StCapture, StWriteback} state_e;

  state_e      state_q;
  logic [15:0] rf_q [16];
  logic [2:0]  opc_q;
  logic [3:0]  rd_q;
  logic [6:0]  imm_q;
  logic [15:0] op_a_q, op_b_q;
  logic [2:0]  opcode_q;
  logic [15:0] r2_q, r3_q;
  logic [3:0]  d1_q;
  logic [6:0]  entrada_q;
  logic        flag_ram_q;
  logic [15:0] retired_q;

  logic [2:0] instr_opc;
  logic [3:0] instr_rd, instr_rs1, instr_rs2;
  logic [6:0] instr_imm;

  assign instr_opc = bus.instr[21:19];
  assign instr_rd  = bus.instr[18:15];
  assign instr_rs1 = bus.instr[14:11];
  assign instr_rs2 = bus.instr[10:7];
  assign instr_imm = bus.instr[6:0];

`ifdef ALU_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      opc_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opcode_q   <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      d1_q       <= '0;
      entrada_q  <= '0;
      flag_ram_q <= 1'b0;
      retired_q  <= '0;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      flag_ram_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Operands are read at accept so a later write to rd cannot alias them.
          if (bus.instr_valid) begin
            opc_q   <= instr_opc;
            rd_q    <= instr_rd;
            imm_q   <= instr_imm;
            op_a_q  <= rf_q[instr_rs1];
            op_b_q  <= rf_q[instr_rs2];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          opcode_q  <= opc_q;
          r2_q      <= op_a_q;
          r3_q      <= op_b_q;
          d1_q      <= rd_q;
          entrada_q <= imm_q;
          state_q   <= StWaitFim;
`ifdef ALU_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StWaitFim: begin
          if (bus.fimop) begin
            state_q <= StCapture;
          end
`ifdef ALU_TIMEOUT_EN
          // Count 254 is the 255th consecutive cycle without fimop.
          else if (tmo_cnt_q == 8'd254) begin
            err_q      <= 1'b1;
            flag_ram_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        StCapture: begin
          flag_ram_q <= 1'b1;
          state_q    <= StWriteback;
        end
        StWriteback: begin
          rf_q[rd_q] <= bus.saida;
          retired_q  <= retired_q + 16'd1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.opcode      = opcode_q;
  assign bus.r2          = r2_q;
  assign bus.r3          = r3_q;
  assign bus.D1          = d1_q;
  assign bus.entrada     = entrada_q;
  assign bus.flag_ram    = flag_ram_q;
  assign busy            = (state_q != StIdle);
  assign retired         = retired_q;
  assign dbg_data        = rf_q[dbg_addr];

endmodule
